// File: rtl/shift_normalizer_if.sv
// Request/result bundle between a controller and the shift normalizer.
// The controller holds the master side; the normalizer is the slave.
interface shift_normalizer_if #(
    parameter int WIDTH = 16,
    parameter int CW    = 5
) ();
    logic             start;
    logic             mode;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] dout;
    logic [CW-1:0]    count;
    logic             zero;
    logic             busy;
    logic             done;

    modport master (
        output start, mode, din,
        input  dout, count, zero, busy, done
    );

    modport slave (
        input  start, mode, din,
        output dout, count, zero, busy, done
    );
endinterface

// File: rtl/shift_normalizer.sv
// Iterative normalizer: shifts an operand left one bit per cycle until its MSB
// is 1 (unsigned) or differs from MSB-1 (signed), then reports result and count.
module shift_normalizer #(
    parameter int WIDTH = 16,
    parameter int CW    = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    shift_normalizer_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] work_p0;
    logic [CW-1:0]    cnt_p0;
    logic             mode_p0;
    logic [WIDTH-1:0] dout_p1;
    logic [CW-1:0]    count_p1;
    logic             zero_p1;
    logic             busy_p1;
    logic             done_p1;
    logic             is_zero;
    logic             is_norm;

    function automatic logic normalized(input logic [WIDTH-1:0] w, input logic signed_mode);
        if (signed_mode)
            return w[WIDTH-1] ^ w[WIDTH-2];
        else
            return w[WIDTH-1];
    endfunction

    assign is_zero = (work_p0 == '0);
    assign is_norm = normalized(work_p0, mode_p0);

    // Working operand and shift counter: loaded on accept, advanced while shifting.
    always_ff @(posedge clk) begin
        if (state == IDLE && bus.start) begin
            work_p0 <= bus.din;
            cnt_p0  <= '0;
            mode_p0 <= bus.mode;
        end else if (state == SHIFT && !is_zero && !is_norm) begin
            work_p0 <= {work_p0[WIDTH-2:0], 1'b0};
            cnt_p0  <= cnt_p0 + CW'(1);
        end
    end

    // Control FSM with registered result/status outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            dout_p1  <= '0;
            count_p1 <= '0;
            zero_p1  <= 1'b0;
            busy_p1  <= 1'b0;
            done_p1  <= 1'b0;
        end else begin
            done_p1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        zero_p1 <= 1'b0;
                        busy_p1 <= 1'b1;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    // An all-zero word never normalizes, so it is caught first.
                    if (is_zero) begin
                        dout_p1  <= '0;
                        count_p1 <= CW'(WIDTH);
                        zero_p1  <= 1'b1;
                        busy_p1  <= 1'b0;
                        done_p1  <= 1'b1;
                        state    <= DONE;
                    end else if (is_norm) begin
                        dout_p1  <= work_p0;
                        count_p1 <= cnt_p0;
                        busy_p1  <= 1'b0;
                        done_p1  <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    busy_p1 <= 1'b0;
                end
            endcase
        end
    end

    assign bus.dout  = dout_p1;
    assign bus.count = count_p1;
    assign bus.zero  = zero_p1;
    assign bus.busy  = busy_p1;
    assign bus.done  = done_p1;

endmodule

// File: tb/tb_shift_normalizer.sv
// Randomized bench for shift_normalizer: a leading-bit-count reference model
// predicts outputs and timing per cycle; directed cases pin the model itself.
module tb_shift_normalizer;

    localparam int WIDTH = 16;
    localparam int CW    = 5;

    logic clk     = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    shift_normalizer_if #(.WIDTH(WIDTH), .CW(CW)) bus ();

    shift_normalizer #(.WIDTH(WIDTH), .CW(CW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: count leading zeros (unsigned) or redundant sign bits (signed).
    function automatic void ref_norm(input logic [WIDTH-1:0] d, input logic m,
                                     output int n, output logic [WIDTH-1:0] r,
                                     output int c, output logic z);
        int lead;
        lead = 0;
        if (d == '0) begin
            n = 0; r = '0; c = WIDTH; z = 1'b1;
            return;
        end
        if (!m) begin
            while (lead < WIDTH && d[WIDTH-1-lead] == 1'b0) lead++;
            n = lead;
        end else begin
            while (lead < WIDTH && d[WIDTH-1-lead] == d[WIDTH-1]) lead++;
            n = lead - 1;
        end
        r = d << n;
        c = n;
        z = 1'b0;
    endfunction

    // Cycle-level expectation derived from the latency rules.
    int               e = 0;
    int               done_edge = 0;
    bit               active = 1'b0;
    logic [WIDTH-1:0] exp_dout = '0;
    logic [CW-1:0]    exp_count = '0;
    logic             exp_zero = 1'b0;
    logic             exp_busy = 1'b0;
    logic             exp_done = 1'b0;
    logic [WIDTH-1:0] pend_dout;
    logic             pend_zero;
    int               pend_count;
    int               pend_n;
    int               model_dones = 0;
    int               dut_dones = 0;
    bit               checking = 1'b0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            active    = 1'b0;
            exp_dout  = '0;
            exp_count = '0;
            exp_zero  = 1'b0;
            exp_busy  = 1'b0;
            exp_done  = 1'b0;
        end else begin
            e++;
            exp_done = 1'b0;
            if (active && e == done_edge) begin
                exp_dout  = pend_dout;
                exp_count = pend_count[CW-1:0];
                exp_zero  = pend_zero;
                exp_busy  = 1'b0;
                exp_done  = 1'b1;
                model_dones++;
            end else if (active && e == done_edge + 1) begin
                active = 1'b0;
            end else if (!active && bus.start) begin
                ref_norm(bus.din, bus.mode, pend_n, pend_dout, pend_count, pend_zero);
                done_edge = e + pend_n + 1;
                active    = 1'b1;
                exp_busy  = 1'b1;
                exp_zero  = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            chk("dout", bus.dout, exp_dout);
            chk("count", bus.count, exp_count);
            if (!exp_busy) chk("zero", bus.zero, exp_zero);
            chk("busy", bus.busy, exp_busy);
            chk("done", bus.done, exp_done);
            if (bus.done) dut_dones++;
        end
    end

    task automatic run_op(input logic [WIDTH-1:0] d, input logic m, input bit noisy, output int lat);
        @(posedge clk);
        #2 bus.start = 1'b1; bus.din = d; bus.mode = m;
        @(posedge clk);
        #2 bus.start = noisy; bus.din = WIDTH'($urandom); bus.mode = 1'($urandom);
        lat = 0;
        forever begin
            @(negedge clk);
            if (lat > 0 && bus.done) break;
            if (lat > 40) begin
                chk("done timeout", 32'(lat), 32'(pend_n + 1));
                break;
            end
            @(posedge clk);
            lat++;
            #2 if (noisy) bus.start = 1'($urandom);
        end
        if (noisy) bus.start = 1'b1;
        else       bus.start = 1'b0;
        @(posedge clk);
        #2 bus.start = 1'b0;
    endtask

    initial begin
        int               lat, n, c, dcount;
        logic [WIDTH-1:0] r, d;
        logic             z, m;

        bus.start = 1'b0;
        bus.mode  = 1'b0;
        bus.din   = '0;
        #1 reset_n = 1'b0;
        checking = 1'b1;
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;
        chk("reset dout", bus.dout, 0);
        chk("reset busy", bus.busy, 0);

        ref_norm(16'h0003, 1'b1, n, r, c, z);
        chk("model s0003 dout", r, 16'h6000);
        chk("model s0003 count", c, 13);
        ref_norm(16'hFFFF, 1'b1, n, r, c, z);
        chk("model sFFFF dout", r, 16'h8000);
        chk("model sFFFF count", c, 15);
        ref_norm(16'h0000, 1'b0, n, r, c, z);
        chk("model zero count", c, 16);
        chk("model zero flag", z, 1);

        run_op(16'h0001, 1'b0, 1'b0, lat);
        chk("u0001 lat", lat, 16);
        chk("u0001 dout", bus.dout, 16'h8000);
        chk("u0001 count", bus.count, 15);
        chk("u0001 zero", bus.zero, 0);

        run_op(16'h8000, 1'b0, 1'b0, lat);
        chk("u8000 lat", lat, 1);
        chk("u8000 count", bus.count, 0);
        chk("u8000 dout", bus.dout, 16'h8000);

        run_op(16'h0000, 1'b0, 1'b0, lat);
        chk("u0000 lat", lat, 1);
        chk("u0000 count", bus.count, 16);
        chk("u0000 zero", bus.zero, 1);
        chk("u0000 dout", bus.dout, 0);

        run_op(16'h0003, 1'b1, 1'b0, lat);
        chk("s0003 dout", bus.dout, 16'h6000);
        chk("s0003 count", bus.count, 13);
        run_op(16'hFFF0, 1'b1, 1'b0, lat);
        chk("sFFF0 dout", bus.dout, 16'h8000);
        chk("sFFF0 count", bus.count, 11);
        run_op(16'hFFFF, 1'b1, 1'b0, lat);
        chk("sFFFF dout", bus.dout, 16'h8000);
        chk("sFFFF count", bus.count, 15);
        chk("sFFFF lat", lat, 16);

        run_op(16'h0001, 1'b0, 1'b1, lat);
        chk("noisy u0001 lat", lat, 16);
        chk("noisy u0001 count", bus.count, 15);
        run_op(16'h0003, 1'b1, 1'b1, lat);
        chk("noisy s0003 count", bus.count, 13);

        // Abort an operation after five shifts with a one-cycle reset pulse.
        @(posedge clk);
        #2 bus.start = 1'b1; bus.din = 16'h0001; bus.mode = 1'b0;
        @(posedge clk);
        #2 bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("abort dout", bus.dout, 0);
        chk("abort count", bus.count, 0);
        chk("abort busy", bus.busy, 0);
        chk("abort done", bus.done, 0);
        @(posedge clk);
        #2 reset_n = 1'b1;
        dcount = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.done) dcount++;
        end
        chk("abort no done", dcount, 0);
        run_op(16'h0100, 1'b0, 1'b0, lat);
        chk("after abort count", bus.count, 7);
        chk("after abort dout", bus.dout, 16'h8000);

        for (int i = 0; i < 1000; i++) begin
            d = WIDTH'($urandom) >> $urandom_range(0, WIDTH);
            m = 1'($urandom);
            if (m && $urandom_range(0, 1) == 1) d = ~d;
            ref_norm(d, m, n, r, c, z);
            run_op(d, m, ($urandom_range(0, 3) == 0), lat);
            chk("rand lat", lat, n + 1);
            chk("rand dout", bus.dout, r);
            chk("rand count", bus.count, c);
            chk("rand zero", bus.zero, z);
        end

        repeat (4) @(posedge clk);
        chk("done pulses", dut_dones, model_dones);
        checking = 1'b0;
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
